// File: rtl/boot_if.sv
// Loader-side bus: host byte stream in, memory write port and CPU control out.
interface boot_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        cpu_reset_n;
    logic        done;
    logic        error;

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_addr, mem_wdata, mem_wr, cpu_reset_n, done, error
    );

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_addr, mem_wdata, mem_wr, cpu_reset_n, done, error
    );
endinterface

// File: rtl/boot_loader.sv
// Byte-stream program loader for the multicycle MIPS memory; holds the CPU in reset until loaded.
// Optional checksum byte and accumulator enabled by defining BOOT_CHECKSUM_EN.
//
// state   | meaning
// S_LEN   | collecting the 4-byte little-endian word count
// S_DATA  | collecting the 4 bytes of the current payload word
// S_WRITE | one-cycle memory write of the assembled word
// S_CHK   | waiting for the checksum byte
// S_RUN   | image accepted, CPU released (terminal)
// S_ERR   | length or checksum failure, CPU held (terminal)
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 64
) (
    input  logic   clock,
    input  logic   reset,
    boot_if.slave  bus
);

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_CHK   = 3'd3,
        S_RUN   = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [31:0] len;
    logic [31:0] word_buf;
    logic [31:0] idx;
    logic        rx_ready;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_reset_n;
    logic        done;
    logic        error;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    logic        xfer;
    logic [31:0] len_full;
    logic [31:0] word_full;
    logic [31:0] idx_next;

    // rx_ready is a register, so the handshake never sees a comb path from rx_* to outputs.
    assign xfer      = bus.rx_valid && rx_ready;
    assign len_full  = {bus.rx_data, len[31:8]};
    assign word_full = {bus.rx_data, word_buf[31:8]};
    assign idx_next  = idx + 32'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_LEN;
            byte_cnt    <= 2'd0;
            len         <= 32'd0;
            word_buf    <= 32'd0;
            idx         <= 32'd0;
            rx_ready    <= 1'b1;
            mem_wr      <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            cpu_reset_n <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
            csum        <= 8'd0;
`endif
        end else begin
            mem_wr <= 1'b0;
            case (state)
                S_LEN: begin
                    if (xfer) begin
                        len      <= len_full;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                        csum     <= csum + bus.rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            if (len_full > 32'(MAX_WORDS)) begin
                                state    <= S_ERR;
                                rx_ready <= 1'b0;
                                error    <= 1'b1;
                            end else if (len_full == 32'd0) begin
`ifdef BOOT_CHECKSUM_EN
                                state       <= S_CHK;
`else
                                state       <= S_RUN;
                                rx_ready    <= 1'b0;
                                cpu_reset_n <= 1'b1;
                                done        <= 1'b1;
`endif
                            end else begin
                                state <= S_DATA;
                                idx   <= 32'd0;
                            end
                        end
                    end
                end

                S_DATA: begin
                    if (xfer) begin
                        word_buf <= word_full;
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef BOOT_CHECKSUM_EN
                        csum     <= csum + bus.rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            state     <= S_WRITE;
                            rx_ready  <= 1'b0;
                            mem_wr    <= 1'b1;
                            mem_addr  <= BASE_ADDR + {idx[29:0], 2'b00};
                            mem_wdata <= word_full;
                        end
                    end
                end

                S_WRITE: begin
                    idx <= idx_next;
                    if (idx_next == len) begin
`ifdef BOOT_CHECKSUM_EN
                        state    <= S_CHK;
                        rx_ready <= 1'b1;
`else
                        state       <= S_RUN;
                        cpu_reset_n <= 1'b1;
                        done        <= 1'b1;
`endif
                    end else begin
                        state    <= S_DATA;
                        rx_ready <= 1'b1;
                    end
                end

`ifdef BOOT_CHECKSUM_EN
                S_CHK: begin
                    if (xfer) begin
                        rx_ready <= 1'b0;
                        if (bus.rx_data == csum) begin
                            state       <= S_RUN;
                            cpu_reset_n <= 1'b1;
                            done        <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end
                end
`endif

                S_RUN, S_ERR: begin
                end

                default: begin
                    state       <= S_ERR;
                    rx_ready    <= 1'b0;
                    cpu_reset_n <= 1'b0;
                    error       <= 1'b1;
                end
            endcase
        end
    end

    assign bus.rx_ready    = rx_ready;
    assign bus.mem_wr      = mem_wr;
    assign bus.mem_addr    = mem_addr;
    assign bus.mem_wdata   = mem_wdata;
    assign bus.cpu_reset_n = cpu_reset_n;
    assign bus.done        = done;
    assign bus.error       = error;

endmodule

// File: tb/tb_boot_loader.sv
// Scoreboard bench for boot_loader: stimulus queues expected writes, a monitor checks them.
module tb_boot_loader;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    boot_if bus ();

    boot_loader #(.BASE_ADDR(32'h0000_0000), .MAX_WORDS(64)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          gap;
    } wr_t;

    wr_t         exp_q[$];
    logic [31:0] img[4];
    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;

    always @(posedge clock) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // Monitor: every write strobe must match the head of the expected queue.
    always @(negedge clock) begin
        wr_t e;
        if (reset === 1'b1 && bus.mem_wr === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected mem_wr: addr 0x%08h data 0x%08h, expected no write",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("mem_addr", bus.mem_addr, e.addr);
                chk("mem_wdata", bus.mem_wdata, e.data);
                if (e.gap >= 0) chk("write spacing", 32'(cyc - last_wr_cyc), 32'(e.gap));
            end
            last_wr_cyc = cyc;
        end
    end

    // Called at a negedge; returns at the negedge right after the transfer edge.
    task automatic send_byte(input logic [7:0] b);
        int k;
        k = 0;
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        while (bus.rx_ready !== 1'b1 && k < 50) begin
            @(negedge clock);
            k++;
        end
        if (k >= 50) begin
            n_checks++;
            $display("FAIL send_byte timeout: rx_ready=%b, required 1", bus.rx_ready);
        end else begin
            @(negedge clock);
        end
    endtask

    task automatic load_image(input logic [31:0] n, input int nw, input logic [7:0] adj);
        logic [7:0] sum;
        wr_t        e;
        sum = 8'd0;
        for (int i = 0; i < 4; i++) begin
            send_byte(n[8*i +: 8]);
            sum = sum + n[8*i +: 8];
        end
        for (int w = 0; w < nw; w++) begin
            e.addr = 32'(w * 4);
            e.data = img[w];
            e.gap  = (w == 0) ? -1 : 5;
            exp_q.push_back(e);
            for (int b = 0; b < 4; b++) begin
                send_byte(img[w][8*b +: 8]);
                sum = sum + img[w][8*b +: 8];
            end
        end
`ifdef BOOT_CHECKSUM_EN
        send_byte(sum + adj);
`else
        if (adj != 8'd0) sum = sum + adj;
        if (nw > 0) @(negedge clock);
`endif
        bus.rx_valid = 1'b0;
    endtask

    task automatic status(input string name, input logic d, input logic err,
                          input logic cpu, input logic rdy);
        chk({name, " done"}, 32'(bus.done), 32'(d));
        chk({name, " error"}, 32'(bus.error), 32'(err));
        chk({name, " cpu_reset_n"}, 32'(bus.cpu_reset_n), 32'(cpu));
        chk({name, " rx_ready"}, 32'(bus.rx_ready), 32'(rdy));
    endtask

    task automatic check_reset_values(input string name);
        status(name, 1'b0, 1'b0, 1'b0, 1'b1);
        chk({name, " mem_wr"}, 32'(bus.mem_wr), 32'd0);
        chk({name, " mem_addr"}, bus.mem_addr, 32'd0);
        chk({name, " mem_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        bus.rx_valid = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        bus.rx_data  = 8'd0;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b1;
        @(negedge clock);

        // One word, checksum 0x15.
        img[0] = 32'h1234_5678;
        load_image(32'd1, 1, 8'h00);
        status("load1", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("load1 mem_addr hold", bus.mem_addr, 32'h0);
        chk("load1 mem_wdata hold", bus.mem_wdata, 32'h1234_5678);

        // Three words at full rate.
        do_reset();
        img[0] = 32'h0302_0100;
        img[1] = 32'hDEAD_BEEF;
        img[2] = 32'h0BAD_F00D;
        load_image(32'd3, 3, 8'h00);
        status("load3", 1'b1, 1'b0, 1'b1, 1'b0);
        chk("load3 mem_addr hold", bus.mem_addr, 32'h8);

        // Length 65 exceeds MAX_WORDS.
        do_reset();
        send_byte(8'h41); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        bus.rx_valid = 1'b0;
        status("len65", 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clock);
        status("len65 sticky", 1'b0, 1'b1, 1'b0, 1'b0);

        // Length 64 is the largest accepted count: still loading after the length bytes.
        do_reset();
        send_byte(8'h40); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        bus.rx_valid = 1'b0;
        status("len64", 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef BOOT_CHECKSUM_EN
        // Bad checksum 0x16: word still written, then error.
        do_reset();
        img[0] = 32'h1234_5678;
        load_image(32'd1, 1, 8'h01);
        status("badsum", 1'b0, 1'b1, 1'b0, 1'b0);
`endif

        // Reset mid-word, then a fresh full image.
        do_reset();
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
        send_byte(8'hAA); send_byte(8'hBB);
        bus.rx_valid = 1'b0;
        #2 reset = 1'b0;
        #1 check_reset_values("async reset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        img[0] = 32'hCAFE_BABE;
        load_image(32'd1, 1, 8'h00);
        status("reload", 1'b1, 1'b0, 1'b1, 1'b0);

        // Empty image.
        do_reset();
        load_image(32'd0, 0, 8'h00);
        status("empty", 1'b1, 1'b0, 1'b1, 1'b0);

        repeat (5) @(negedge clock);
        chk("pending writes", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required finish");
        $fatal(1, "watchdog");
    end

endmodule
